// File: rtl/trap_pkg.sv
// trap_pkg: shared state encoding and mcause constants for the trap sequencer.
package trap_pkg;
  typedef enum logic [2:0] {
    IDLE,
    TRAP,
    FLUSH,
    REDIRECT,
    HANDLER,
    RET_FLUSH,
    RET_REDIRECT
  } trap_state_t;
  localparam logic [31:0] CAUSE_STACK    = 32'h0000_0018;
  localparam logic [31:0] CAUSE_ECALL    = 32'h0000_000B;
  localparam logic [31:0] CAUSE_UART_IRQ = 32'h8000_000B;
  localparam logic [1:0]  MTVEC_VECTORED = 2'b01;
endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: picks the highest-priority pending trap source and its mcause.
module trap_prio_enc
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            stack,
  input  logic            ecall,
  input  logic            irq,
  input  logic            ex_valid,
  input  logic            mstatus_mie,
  input  logic            mie_meie,
  output logic            take,
  output logic [XLEN-1:0] cause
);
  logic ecall_ok, irq_ok;
  assign ecall_ok = ecall & ex_valid;
  assign irq_ok   = irq & mstatus_mie & mie_meie & ex_valid;
  assign take     = stack | ecall_ok | irq_ok;
  // interrupt flag is always the top bit regardless of XLEN
  assign cause = stack    ? XLEN'(CAUSE_STACK) :
                 ecall_ok ? XLEN'(CAUSE_ECALL) :
                            {1'b1, (XLEN-1)'(CAUSE_UART_IRQ[30:0])};
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap entry/return sequencer driving the CSR capture strobe and pipeline flush/redirect.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ecall,
  input  logic            mret,
  input  logic            stack_mismatch,
  input  logic            uart_irq,
  input  logic            mstatus_mie,
  input  logic            mie_meie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            trigger_trap,
  output logic [XLEN-1:0] cause,
  output logic [XLEN-1:0] epc,
  output logic            stall,
  output logic            flush,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trapping
);
  trap_state_t     state, nxt;
  logic [2:0]      cnt;
  logic            pending_sm, take;
  logic [XLEN-1:0] enc_cause, cause_q, epc_q, base, target;
  trap_prio_enc #(.XLEN(XLEN)) u_enc (
    .stack       (stack_mismatch | pending_sm),
    .ecall       (ecall),
    .irq         (uart_irq),
    .ex_valid    (ex_valid),
    .mstatus_mie (mstatus_mie),
    .mie_meie    (mie_meie),
    .take        (take),
    .cause       (enc_cause)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pending_sm <= 1'b0;
      cause_q    <= '0;
      epc_q      <= '0;
    end else begin
      state <= nxt;
      if (state == TRAP) cnt <= 3'(FLUSH_CYCLES - 1);
      else if (state == FLUSH && cnt != 0) cnt <= cnt - 3'd1;
      if (state == IDLE && take) begin
        cause_q <= enc_cause;
        epc_q   <= ex_pc;
      end
      // a stack trap taken from IDLE consumes the pending flag
      if (state == IDLE && take && enc_cause == XLEN'(CAUSE_STACK)) pending_sm <= 1'b0;
      else if (state != IDLE && stack_mismatch) pending_sm <= 1'b1;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:         nxt = take ? TRAP : IDLE;
      TRAP:         nxt = FLUSH;
      FLUSH:        nxt = cnt == 0 ? REDIRECT : FLUSH;
      REDIRECT:     nxt = HANDLER;
      HANDLER:      nxt = mret & ex_valid ? RET_FLUSH : HANDLER;
      RET_FLUSH:    nxt = RET_REDIRECT;
      RET_REDIRECT: nxt = IDLE;
      default:      nxt = IDLE;
    endcase
  end
  assign base   = {mtvec[XLEN-1:2], 2'b00};
  assign target = base + ((mtvec[1:0] == MTVEC_VECTORED && cause_q[XLEN-1]) ?
                          XLEN'({cause_q[4:0], 2'b00}) : '0);
  always_comb begin
    trigger_trap = state == TRAP;
    cause        = state == TRAP ? cause_q : '0;
    epc          = state == TRAP ? epc_q : '0;
    stall        = state inside {TRAP, FLUSH, REDIRECT, RET_FLUSH};
    flush        = state inside {FLUSH, RET_FLUSH};
    redirect     = state inside {REDIRECT, RET_REDIRECT};
    redirect_pc  = state == REDIRECT ? target : state == RET_REDIRECT ? mepc : '0;
    trapping     = state inside {HANDLER, RET_FLUSH};
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed vector table plus reset corner sequence for trap_ctrl.
module tb_trap_ctrl;
  localparam logic [6:0] EV = 7'b1000000, EC = 7'b0100000, MR = 7'b0010000, SM = 7'b0001000;
  localparam logic [6:0] IRQ = 7'b0000100, MIE = 7'b0000010, MEIE = 7'b0000001;
  localparam logic [6:0] IE = EV | IRQ | MIE | MEIE;
  localparam logic [4:0] O_I = 5'b00000, O_T = 5'b11000, O_F = 5'b01100, O_R = 5'b01010;
  localparam logic [4:0] O_H = 5'b00001, O_RF = 5'b01101, O_RR = 5'b00010;
  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] pc, tvec, mepc_in;
    logic [4:0]  o;
    logic [31:0] c, e, r;
  } vec_t;
  logic clk = 0, rst = 1;
  logic ex_valid = 0, ecall = 0, mret = 0, stack_mismatch = 0, uart_irq = 0, mstatus_mie = 0, mie_meie = 0;
  logic [31:0] ex_pc = 0, mtvec = 0, mepc = 0;
  logic trigger_trap, stall, flush, redirect, trapping;
  logic [31:0] cause, epc, redirect_pc;
  int n_vec = 0, n_bad = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  trap_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .ecall(ecall), .mret(mret),
    .stack_mismatch(stack_mismatch), .uart_irq(uart_irq), .mstatus_mie(mstatus_mie),
    .mie_meie(mie_meie), .mtvec(mtvec), .mepc(mepc), .trigger_trap(trigger_trap),
    .cause(cause), .epc(epc), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .trapping(trapping)
  );
  function automatic void add(logic [6:0] ctl, logic [31:0] pc, logic [31:0] tv, logic [31:0] me,
                              logic [4:0] o, logic [31:0] c, logic [31:0] e, logic [31:0] r);
    vec_t v;
    v.ctl = ctl; v.pc = pc; v.tvec = tv; v.mepc_in = me; v.o = o; v.c = c; v.e = e; v.r = r;
    tbl.push_back(v);
  endfunction
  task automatic drive(logic [6:0] ctl, logic [31:0] pc, logic [31:0] tv, logic [31:0] me);
    {ex_valid, ecall, mret, stack_mismatch, uart_irq, mstatus_mie, mie_meie} = ctl;
    ex_pc = pc; mtvec = tv; mepc = me;
  endtask
  task automatic chk(string name, logic [4:0] o, logic [31:0] c, logic [31:0] e, logic [31:0] r);
    logic [4:0] got;
    got = {trigger_trap, stall, flush, redirect, trapping};
    n_vec++;
    if (got !== o || cause !== c || epc !== e || redirect_pc !== r) begin
      n_bad++;
      $display("FAIL %s: got ctl=%b cause=%h epc=%h rpc=%h, want ctl=%b cause=%h epc=%h rpc=%h",
               name, got, cause, epc, redirect_pc, o, c, e, r);
    end
  endtask
  initial begin
    // ecall entry with direct mtvec, ignored ecall in handler, mret return
    add(EV|EC, 32'h100, 32'h200, 0, O_T, 32'hB, 32'h100, 0);
    add(0, 0, 32'h200, 0, O_F, 0, 0, 0);
    add(0, 0, 32'h200, 0, O_F, 0, 0, 0);
    add(0, 0, 32'h200, 0, O_R, 0, 0, 32'h200);
    add(0, 0, 32'h200, 0, O_H, 0, 0, 0);
    add(EV|EC, 0, 32'h200, 0, O_H, 0, 0, 0);
    add(EV|MR, 0, 32'h200, 32'h104, O_RF, 0, 0, 0);
    add(0, 0, 32'h200, 32'h104, O_RR, 0, 0, 32'h104);
    add(0, 0, 32'h200, 0, O_I, 0, 0, 0);
    // mret in IDLE and gated interrupts do nothing
    add(EV|MR, 0, 32'h200, 32'h104, O_I, 0, 0, 0);
    add(EV|IRQ|MIE, 0, 32'h201, 0, O_I, 0, 0, 0);
    add(EV|IRQ|MEIE, 0, 32'h201, 0, O_I, 0, 0, 0);
    // vectored interrupt, stack mismatch pending through handler
    add(IE, 32'h300, 32'h201, 0, O_T, 32'h8000_000B, 32'h300, 0);
    add(0, 0, 32'h201, 0, O_F, 0, 0, 0);
    add(0, 0, 32'h201, 0, O_F, 0, 0, 0);
    add(0, 0, 32'h201, 0, O_R, 0, 0, 32'h22C);
    add(0, 0, 32'h201, 0, O_H, 0, 0, 0);
    add(SM, 0, 32'h201, 0, O_H, 0, 0, 0);
    add(EV|MR, 0, 32'h201, 32'h304, O_RF, 0, 0, 0);
    add(0, 0, 32'h201, 32'h304, O_RR, 0, 0, 32'h304);
    add(0, 0, 32'h201, 0, O_I, 0, 0, 0);
    add(0, 32'h400, 32'h201, 0, O_T, 32'h18, 32'h400, 0);
    add(0, 0, 32'h201, 0, O_F, 0, 0, 0);
    add(0, 0, 32'h201, 0, O_F, 0, 0, 0);
    add(0, 0, 32'h201, 0, O_R, 0, 0, 32'h200);
    add(0, 0, 32'h201, 0, O_H, 0, 0, 0);
    add(EV|MR, 0, 32'h201, 32'h404, O_RF, 0, 0, 0);
    add(0, 0, 32'h201, 32'h404, O_RR, 0, 0, 32'h404);
    add(0, 0, 32'h201, 0, O_I, 0, 0, 0);
    // all three sources at once: stack wins, level interrupt taken after mret
    add(IE|EC|SM, 32'h500, 32'h201, 0, O_T, 32'h18, 32'h500, 0);
    add(IE, 0, 32'h201, 0, O_F, 0, 0, 0);
    add(IE, 0, 32'h201, 0, O_F, 0, 0, 0);
    add(IE, 0, 32'h201, 0, O_R, 0, 0, 32'h200);
    add(IE, 0, 32'h201, 0, O_H, 0, 0, 0);
    add(IE|MR, 0, 32'h201, 32'h504, O_RF, 0, 0, 0);
    add(IE, 0, 32'h201, 32'h504, O_RR, 0, 0, 32'h504);
    add(IE, 32'h508, 32'h201, 0, O_I, 0, 0, 0);
    add(IE, 32'h508, 32'h201, 0, O_T, 32'h8000_000B, 32'h508, 0);
    add(IE, 0, 32'h201, 0, O_F, 0, 0, 0);
    add(IE, 0, 32'h201, 0, O_F, 0, 0, 0);
    add(IE, 0, 32'h201, 0, O_R, 0, 0, 32'h22C);
    add(IE, 0, 32'h201, 0, O_H, 0, 0, 0);
    add(EV|MR, 0, 32'h201, 32'h50C, O_RF, 0, 0, 0);
    add(0, 0, 32'h201, 32'h50C, O_RR, 0, 0, 32'h50C);
    add(0, 0, 32'h201, 0, O_I, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 chk("reset", O_I, 0, 0, 0);
    @(negedge clk) rst = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk) drive(tbl[i].ctl, tbl[i].pc, tbl[i].tvec, tbl[i].mepc_in);
      @(posedge clk) #1 chk($sformatf("vec%0d", i), tbl[i].o, tbl[i].c, tbl[i].e, tbl[i].r);
    end
    // async reset during FLUSH aborts the sequence and drops a pending stack event
    @(negedge clk) drive(EV|EC, 32'h600, 32'h200, 0);
    @(posedge clk) #1 chk("rst_seq_trap", O_T, 32'hB, 32'h600, 0);
    @(negedge clk) drive(SM, 0, 32'h200, 0);
    @(posedge clk) #1 chk("rst_seq_flush", O_F, 0, 0, 0);
    @(negedge clk) drive(0, 0, 32'h200, 0);
    #2 rst = 1;
    #1 chk("rst_async", O_I, 0, 0, 0);
    @(posedge clk) #1 chk("rst_held", O_I, 0, 0, 0);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk) #1 chk($sformatf("post_rst%0d", i), O_I, 0, 0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer for the Mini-RISC-V core. Sits directly upstream of the CSR file.
- Arbitrates trap sources: stack-mismatch, ecall, UART interrupt.
- Issues the one-cycle trigger_trap strobe plus cause/epc that the CSR file captures into mcause/mepc.
- Consumes mtvec/mepc back from the CSR file to flush the pipeline and redirect fetch on trap entry and on mret.

Parameters:
- XLEN, 32, datapath/address width.
- FLUSH_CYCLES, 2, cycles flush is held on trap entry (legal range 1..7).

Ports:
- clk  in  1  core clock.
- Rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  ID/EX holds a real (non-bubble) instruction.
- ex_pc  in  XLEN  ID/EX present address.
- ecall  in  1  ID/EX instruction is ecall.
- mret  in  1  ID/EX instruction is mret.
- stack_mismatch  in  1  one-cycle pulse from the shadow-stack checker.
- uart_irq  in  1  level interrupt from the UART.
- mstatus_mie  in  1  global interrupt enable (mstatus[3]).
- mie_meie  in  1  external interrupt enable (mie[11]).
- mtvec  in  XLEN  from the CSR file.
- mepc  in  XLEN  from the CSR file.
- trigger_trap  out  1  one-cycle capture strobe to the CSR file.
- cause  out  XLEN  mcause value, valid while trigger_trap=1.
- epc  out  XLEN  mepc value, valid while trigger_trap=1.
- stall  out  1  freeze PC/IF.
- flush  out  1  squash IF/ID and ID/EX.
- redirect  out  1  load redirect_pc into the PC.
- redirect_pc  out  XLEN  fetch target.
- trapping  out  1  handler in progress.

Behaviour:
- Reset (async, Rst=1): state IDLE, pending_sm=0, flush counter 0, all outputs 0.
- Reset mid-sequence aborts the sequence immediately and drops any pending event.
- States: IDLE, TRAP, FLUSH, REDIRECT, HANDLER, RET_FLUSH, RET_REDIRECT.
- Sources, in priority order:
  - Stack mismatch (stack_mismatch | pending_sm): cause 32'h0000_0018. Does not require ex_valid.
  - ecall with ex_valid: cause 32'h0000_000B.
  - Interrupt, uart_irq & mstatus_mie & mie_meie & ex_valid: cause 32'h8000_000B.
- Trap entry, source seen in IDLE at cycle N:
  - N+1 TRAP: trigger_trap=1, stall=1, cause latched, epc=ex_pc latched at N.
  - N+2..N+1+FLUSH_CYCLES FLUSH: flush=1, stall=1, driven by a down-counter.
  - Next cycle REDIRECT: redirect=1, stall=1, then HANDLER.
  - Default FLUSH_CYCLES=2: redirect at N+4.
- Redirect target:
  - base = {mtvec[XLEN-1:2],2'b00}.
  - If mtvec[1:0]==2'b01 and cause[XLEN-1]=1: base + (cause[4:0]<<2), e.g. +44 for the UART interrupt.
  - Otherwise: base.
  - Addition wraps modulo 2^XLEN.
- HANDLER: trapping=1, all other outputs 0.
  - ecall and interrupts are ignored (dropped, not queued).
  - stack_mismatch sets pending_sm.
  - mret & ex_valid -> RET_FLUSH (flush=1, stall=1, one cycle) -> RET_REDIRECT (redirect=1, redirect_pc=mepc sampled that cycle) -> IDLE.
- mret in IDLE is ignored (no redirect).
- pending_sm:
  - Set by stack_mismatch in any non-IDLE state.
  - Cleared when TRAP is entered for that source.
  - Taken on the first IDLE cycle after return.
- Simultaneous ecall + uart_irq in IDLE: ecall wins; the interrupt stays level and is taken after mret.
- trapping deasserts in the RET_REDIRECT cycle.

Decomposition:
- Package trap_pkg:
  - trap_state_t enum.
  - Cause constants CAUSE_STACK, CAUSE_ECALL, CAUSE_UART_IRQ.
  - MTVEC_VECTORED = 2'b01.
- Sub-module trap_prio_enc (combinational): takes the source bits plus enables; produces take, cause.
- The FSM, counter and target adder stay in trap_ctrl.

Test Plan:
- ecall=1, ex_valid=1, ex_pc=32'h0000_0100, mtvec=32'h0000_0200 in IDLE -> trigger_trap at +1 with cause=0xB and epc=0x100; flush at +2 and +3; redirect=1 with redirect_pc=0x200 at +4; trapping=1 from +5.
- uart_irq=1, both enables=1, mtvec=32'h0000_0201 -> cause=0x8000_000B, redirect_pc=0x22C. Repeat with mstatus_mie=0 -> no trap.
- In HANDLER: mret, ex_valid=1, mepc=0x104 -> flush at +1; redirect to 0x104 at +2; IDLE and trapping=0 at +2.
- stack_mismatch pulse during HANDLER -> nothing until mret completes; trap with cause=0x18 on the first IDLE cycle after return.
- ecall + uart_irq + stack_mismatch in the same IDLE cycle -> cause=0x18. After mret the interrupt (still asserted) is taken and ecall is not.
- Rst pulsed during FLUSH -> all outputs 0 immediately; no redirect; IDLE after release.
